// File: rtl/conv_kxk_stream.sv
// conv_kxk_stream
//   Multi-channel KxK convolution engine. Sweeps every valid output position
//   of an IMAGE x IMAGE x CHANNELS feature map, reading one K-pixel row slice
//   per cycle from an external feature RAM. Each slice is multiplied against
//   the internal weight store and accumulated. The bias is then added, and the
//   sum is arithmetically shifted right by FRAC_BITS and saturated.
//
//   Optional build macro: CONV_KXK_RELU_EN (fuses ReLU after saturation).
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           pulse, begins a full-map sweep when idle
//   w_we/w_addr/w_data  weight row write (row = c*K+r, lane 0 in LSBs), idle only
//   b_we/b_data     bias write, idle only
//   fm_addr/fm_data feature RAM read port (data valid one cycle after address)
//   out_data/out_valid  result stream, one pulse per output pixel
//   busy, done      sweep in progress / one-cycle completion pulse
module conv_kxk_stream #(
   parameter int IN_WIDTH    = 8,
   parameter int OUT_WIDTH   = 8,
   parameter int IMAGE       = 32,
   parameter int KERNEL_SIZE = 5,
   parameter int CHANNELS    = 6,
   parameter int FRAC_BITS   = 8,
   parameter int ADDR_W      = $clog2(CHANNELS*IMAGE*IMAGE),
   parameter int WADDR_W     = $clog2(CHANNELS*KERNEL_SIZE+1)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            w_we,
   input  logic [WADDR_W-1:0]              w_addr,
   input  logic [KERNEL_SIZE*IN_WIDTH-1:0] w_data,
   input  logic                            b_we,
   input  logic [IN_WIDTH-1:0]             b_data,
   output logic [ADDR_W-1:0]               fm_addr,
   input  logic [KERNEL_SIZE*IN_WIDTH-1:0] fm_data,
   output logic [OUT_WIDTH-1:0]            out_data,
   output logic                            out_valid,
   output logic                            busy,
   output logic                            done
);

   localparam int K       = KERNEL_SIZE;
   localparam int NROW    = CHANNELS*K;
   localparam int OUT_DIM = IMAGE-K+1;
   localparam int ACC_W   = 2*IN_WIDTH + $clog2(CHANNELS*K*K+1);
   localparam int SUM_W   = ACC_W+1;
   localparam int CW      = $clog2(CHANNELS+1);
   localparam int RW      = $clog2(K+1);
   localparam int PW      = $clog2(OUT_DIM+1);
   localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2**(OUT_WIDTH-1))-1);
   localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2**(OUT_WIDTH-1)));

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINAL, S_FIN} state_t;

   state_t                     r_state, w_next;
   logic [CW-1:0]              r_c;
   logic [RW-1:0]              r_r;
   logic [PW-1:0]              r_ox, r_oy;
   logic                       r_pvld;
   logic [WADDR_W-1:0]         r_prow;
   logic signed [ACC_W-1:0]    r_acc;
   logic [K*IN_WIDTH-1:0]      r_wmem [NROW];
   logic signed [IN_WIDTH-1:0] r_bias;
   logic [OUT_WIDTH-1:0]       r_out;
   logic                       r_ovld;

   logic                          w_last_row, w_last_win;
   logic [K*IN_WIDTH-1:0]         w_wrow;
   logic signed [2*IN_WIDTH-1:0]  w_prod [K];
   logic signed [ACC_W-1:0]       w_mac;
   logic signed [SUM_W-1:0]       w_sum, w_shift;
   logic [OUT_WIDTH-1:0]          w_res;

   assign w_last_row = (r_c == CW'(CHANNELS-1)) && (r_r == RW'(K-1));
   assign w_last_win = (r_ox == PW'(OUT_DIM-1)) && (r_oy == PW'(OUT_DIM-1));
   assign fm_addr    = ADDR_W'((32'(r_c)*IMAGE + 32'(r_oy) + 32'(r_r))*IMAGE + 32'(r_ox));
   assign out_data   = r_out;
   assign out_valid  = r_ovld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         S_IDLE:  if (start) w_next = S_ISSUE;
         S_ISSUE: begin
            busy = 1'b1;
            if (w_last_row) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            busy   = 1'b1;
            w_next = S_FINAL;
         end
         S_FINAL: begin
            busy   = 1'b1;
            w_next = w_last_win ? S_FIN : S_ISSUE;
         end
         S_FIN: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Window/row counters plus a one-cycle delayed weight-row index that
   // lines up with the fm_data returned for the previous address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_c    <= '0;
         r_r    <= '0;
         r_ox   <= '0;
         r_oy   <= '0;
         r_pvld <= 1'b0;
         r_prow <= '0;
         r_acc  <= '0;
         r_out  <= '0;
         r_ovld <= 1'b0;
      end else begin
         r_pvld <= (r_state == S_ISSUE);
         r_prow <= WADDR_W'(32'(r_c)*K + 32'(r_r));
         r_ovld <= (r_state == S_FINAL);
         if (r_pvld) r_acc <= r_acc + w_mac;
         case (r_state)
            S_IDLE: if (start) begin
               r_c   <= '0;
               r_r   <= '0;
               r_ox  <= '0;
               r_oy  <= '0;
               r_acc <= '0;
            end
            S_ISSUE: begin
               if (r_r == RW'(K-1)) begin
                  r_r <= '0;
                  r_c <= w_last_row ? '0 : r_c + 1'b1;
               end else begin
                  r_r <= r_r + 1'b1;
               end
            end
            S_FINAL: begin
               r_out <= w_res;
               r_acc <= '0;
               if (w_last_win) begin
                  r_ox <= '0;
                  r_oy <= '0;
               end else if (r_ox == PW'(OUT_DIM-1)) begin
                  r_ox <= '0;
                  r_oy <= r_oy + 1'b1;
               end else begin
                  r_ox <= r_ox + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Weight and bias stores keep their contents across reset.
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE) begin
         if (w_we && (w_addr < WADDR_W'(NROW))) r_wmem[w_addr] <= w_data;
         if (b_we) r_bias <= b_data;
      end
   end

   always_comb begin
      w_wrow = r_wmem[r_prow];
      w_mac  = '0;
      for (int unsigned k = 0; k < K; k++) begin
         w_prod[k] = $signed(fm_data[k*IN_WIDTH +: IN_WIDTH]) * $signed(w_wrow[k*IN_WIDTH +: IN_WIDTH]);
         w_mac     = w_mac + ACC_W'(w_prod[k]);
      end
   end

   always_comb begin
      w_sum   = SUM_W'(r_acc) + SUM_W'(r_bias);
      w_shift = w_sum >>> FRAC_BITS;
      if (w_shift > SAT_MAX)      w_res = OUT_WIDTH'(SAT_MAX);
      else if (w_shift < SAT_MIN) w_res = OUT_WIDTH'(SAT_MIN);
      else                        w_res = w_shift[OUT_WIDTH-1:0];
`ifdef CONV_KXK_RELU_EN
      if (w_res[OUT_WIDTH-1]) w_res = '0;
`else
`endif
   end

endmodule

// File: tb/tb_conv_kxk_stream.sv
module tb_conv_kxk_stream;

   localparam int IMG   = 7;
   localparam int K     = 3;
   localparam int CH    = 2;
   localparam int FB    = 4;
   localparam int IW    = 8;
   localparam int OW    = 8;
   localparam int OD    = IMG-K+1;
   localparam int NOUT  = OD*OD;
   localparam int CPO   = CH*K+2;
   localparam int SWEEP = NOUT*CPO+1;
   localparam int AW    = $clog2(CH*IMG*IMG);
   localparam int WAW   = $clog2(CH*K+1);
   localparam int OMAX  = (2**(OW-1))-1;
   localparam int OMIN  = -(2**(OW-1));

   logic            clk = 1'b0;
   logic            rst, start, w_we, b_we;
   logic [WAW-1:0]  w_addr;
   logic [K*IW-1:0] w_data;
   logic [IW-1:0]   b_data;
   logic [AW-1:0]   fm_addr;
   logic [K*IW-1:0] fm_data = '0;
   logic [OW-1:0]   out_data;
   logic            out_valid, busy, done;

   int pix [CH][IMG][IMG];
   int wt  [CH][K][K];
   int bias;
   int exp_q [NOUT];
   int n_chk = 0;
   int n_err = 0;

   conv_kxk_stream #(
      .IN_WIDTH(IW), .OUT_WIDTH(OW), .IMAGE(IMG), .KERNEL_SIZE(K),
      .CHANNELS(CH), .FRAC_BITS(FB)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
      .b_we(b_we), .b_data(b_data),
      .fm_addr(fm_addr), .fm_data(fm_data),
      .out_data(out_data), .out_valid(out_valid),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [K*IW-1:0] fm_word(input int a);
      logic [K*IW-1:0] v = '0;
      int c = a/(IMG*IMG);
      int y = (a/IMG)%IMG;
      int x = a%IMG;
      for (int k = 0; k < K; k++)
         if (c < CH && x+k < IMG) v[k*IW +: IW] = IW'(pix[c][y][x+k]);
      return v;
   endfunction

   // Feature RAM: one-cycle read latency.
   always @(posedge clk) fm_data <= fm_word(int'(fm_addr));

   function automatic int ref_out(input int oy, input int ox);
      longint s = 0;
      for (int c = 0; c < CH; c++)
         for (int r = 0; r < K; r++)
            for (int k = 0; k < K; k++)
               s += longint'(pix[c][oy+r][ox+k]) * longint'(wt[c][r][k]);
      s += bias;
      s = s >>> FB;
      if (s > OMAX) s = OMAX;
      if (s < OMIN) s = OMIN;
`ifdef CONV_KXK_RELU_EN
      if (s < 0) s = 0;
`endif
      return int'(s);
   endfunction

   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic fill(input int p0, input int p1, input int w, input int b);
      for (int c = 0; c < CH; c++)
         for (int y = 0; y < IMG; y++)
            for (int x = 0; x < IMG; x++)
               pix[c][y][x] = (c == 0) ? p0 : p1;
      for (int c = 0; c < CH; c++)
         for (int r = 0; r < K; r++)
            for (int k = 0; k < K; k++) wt[c][r][k] = w;
      bias = b;
   endtask

   task automatic fill_rand();
      for (int c = 0; c < CH; c++)
         for (int y = 0; y < IMG; y++)
            for (int x = 0; x < IMG; x++)
               pix[c][y][x] = int'($urandom_range(0, 255)) - 128;
      for (int c = 0; c < CH; c++)
         for (int r = 0; r < K; r++)
            for (int k = 0; k < K; k++) wt[c][r][k] = int'($urandom_range(0, 255)) - 128;
      bias = int'($urandom_range(0, 255)) - 128;
   endtask

   task automatic load();
      for (int c = 0; c < CH; c++)
         for (int r = 0; r < K; r++) begin
            @(negedge clk);
            w_we   = 1'b1;
            w_addr = WAW'(c*K+r);
            for (int k = 0; k < K; k++) w_data[k*IW +: IW] = IW'(wt[c][r][k]);
         end
      @(negedge clk);
      w_addr = WAW'(CH*K);   // out of range row: must be ignored
      w_data = '1;
      b_we   = 1'b1;
      b_data = IW'(bias);
      @(negedge clk);
      w_we = 1'b0;
      b_we = 1'b0;
      for (int oy = 0; oy < OD; oy++)
         for (int ox = 0; ox < OD; ox++) exp_q[oy*OD+ox] = ref_out(oy, ox);
   endtask

   // mode 0: plain sweep; 1: start/w_we/b_we while busy and start on done;
   // 2: reset after three outputs.
   task automatic run(input int mode, input string nm);
      int nv = 0;
      int nd = 0;
      int cyc;
      int done_cyc = -1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      check({nm, "_busy"}, longint'(busy), 1);
      while (cyc <= SWEEP+20 && !(done_cyc >= 0 && cyc > done_cyc+CPO+2)) begin
         if (out_valid) begin
            if (nv < NOUT) check({nm, "_out"}, longint'($signed(out_data)), exp_q[nv]);
            nv++;
            if (mode == 2 && nv == 3) begin
               rst = 1'b1;
               #1;
               check({nm, "_rst_busy"}, longint'(busy), 0);
               check({nm, "_rst_valid"}, longint'(out_valid), 0);
               check({nm, "_rst_done"}, longint'(done), 0);
               check({nm, "_rst_data"}, longint'(out_data), 0);
               @(negedge clk);
               rst = 1'b0;
               return;
            end
         end
         if (done) begin
            nd++;
            if (done_cyc < 0) done_cyc = cyc;
            if (mode == 1) start = 1'b1;
         end
         if (mode == 1 && done_cyc >= 0 && cyc == done_cyc+1) begin
            start = 1'b0;
            check({nm, "_start_on_done"}, longint'(busy), 0);
         end
         if (mode == 1 && cyc == 30) begin
            start  = 1'b1;
            w_we   = 1'b1;
            w_addr = '0;
            w_data = '1;
            b_we   = 1'b1;
            b_data = 8'd100;
         end
         if (mode == 1 && cyc == 31) begin
            start = 1'b0;
            w_we  = 1'b0;
            b_we  = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check({nm, "_count"}, nv, NOUT);
      check({nm, "_ndone"}, nd, 1);
      check({nm, "_latency"}, done_cyc, SWEEP);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; w_we = 1'b0; b_we = 1'b0;
      w_addr = '0; w_data = '0; b_data = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", longint'(busy), 0);
      check("rst_done", longint'(done), 0);
      check("rst_valid", longint'(out_valid), 0);
      check("rst_data", longint'(out_data), 0);
      check("rst_addr", longint'(fm_addr), 0);
      rst = 1'b0;

      fill(1, 1, 1, 0);       load(); run(0, "ones");
      fill(2, 3, 1, -5);      load(); run(0, "bias");
      fill(127, 127, 127, 0); load(); run(0, "sat_hi");
      fill(127, 127, -128, 0); load(); run(0, "sat_lo");
      fill(1, 1, 1, 54);      load(); run(0, "shift_pos");
      fill(1, 1, 0, -17);     load(); run(0, "shift_neg");
      for (int i = 0; i < 3; i++) begin
         fill_rand(); load(); run(0, "rand");
      end
      fill_rand(); load(); run(1, "proto"); run(0, "proto_after");
      fill_rand(); load(); run(2, "midrst"); run(0, "midrst_after");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
